serial_tx: RTL and testbench
============================

Name: serial_tx

Overview:
- Serial transmitter for a single-wire, idle-high line. Accepts a parallel word on a one-cycle Start strobe and sends a framed bit stream: start bit, data bits LSB-first, optional even-parity bit, stop bit.
- It is the sending end of the team's serial link. The capturing side samples the line with the storage elements already in the codebase.
- Each bit is held for a programmable number of clock cycles.

Parameters:
- WIDTH, 8, number of data bits per frame (must be >= 1).
- CLKS_PER_BIT, 4, clock cycles each bit is held on Tx (must be >= 1).
- PARITY_EN, 1, 1 = insert an even-parity bit after the data bits; 0 = no parity bit.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Start  input  1  request to send; sampled on the rising edge.
- Data  input  WIDTH  word to send; captured only on the edge that accepts Start.
- Tx  output  1  serial line; idles high.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Interface: one clock (Clock). Reset is asynchronous and active-high (Reset).
- Reset values, applied immediately on Reset assertion regardless of Clock:
  - Tx=1, Busy=0, Done=0.
  - State=IDLE, bit-cycle counter=0, bit index=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
  - PARITY is skipped entirely when PARITY_EN=0.
- Acceptance: Start is accepted on rising edge k only when State=IDLE and Reset=0. On that edge:
  - Data is captured into the shift register.
  - The parity bit is computed as the XOR of all WIDTH captured bits.
  - State<=START, Tx<=0, Busy<=1.
- Start is ignored when State is not IDLE. Data changes after edge k do not affect the frame.
- Bit timing: a cycle counter runs 0..CLKS_PER_BIT-1 in each non-IDLE state. When it wraps, the FSM advances and Tx takes the next bit value on that same edge.
  - START: Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: Tx = shift register bit 0. The register shifts right on each bit boundary. The bit index counts 0..WIDTH-1. After bit WIDTH-1, go to PARITY if PARITY_EN=1, else go to STOP.
  - PARITY: Tx = parity bit for CLKS_PER_BIT cycles, then go to STOP.
  - STOP: Tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Frame length: F = (WIDTH + 2 + PARITY_EN) * CLKS_PER_BIT cycles. Relative to edge k:
  - data bit i drives Tx from edge k+(1+i)*CLKS_PER_BIT;
  - the parity bit drives Tx from edge k+(1+WIDTH)*CLKS_PER_BIT;
  - the stop bit drives Tx from edge k+(1+WIDTH+PARITY_EN)*CLKS_PER_BIT.
- Completion: on edge k+F:
  - State<=IDLE, Busy<=0, Tx stays 1.
  - Done<=1 for exactly one cycle; it is cleared on the next edge.
- Back-to-back frames:
  - Start held high through the final STOP cycle is not accepted on the completion edge.
  - It is accepted on the next edge (k+F+1), while Done is high.
  - So there is a minimum of 1 idle cycle with Tx=1 between frames, and consecutive accept edges are >= F+1 cycles apart.
- Start held high continuously: a new frame is sent every F+1 cycles, each using Data as captured at its own accept edge.
- Reset mid-frame:
  - Tx returns to 1 and Busy to 0 immediately. Done is not pulsed.
  - A Start on the first edge after Reset deasserts is accepted normally.
- Width rules:
  - The bit-cycle counter is sized as ceil(log2(CLKS_PER_BIT)), minimum 1 bit.
  - The bit index is sized as ceil(log2(WIDTH)), minimum 1 bit.
  - CLKS_PER_BIT=1 must work, giving one cycle per bit.
- No X allowed on any output after reset.

Test Plan:
1. Reset held, then released with Start=0 -> Tx=1, Busy=0, Done=0 for 20 cycles. Assert Reset asynchronously between clock edges -> outputs reset values immediately.
2. Defaults (WIDTH=8, CPB=4, PAR=1), Data=8'hA5, Start pulsed at edge k:
   - Tx over 44 cycles = 0, then 1,0,1,0,0,1,0,1 (LSB first), then parity 0, then stop 1, each bit 4 cycles.
   - Busy high edges k..k+43.
   - Done high exactly cycle k+44.
3. Data=8'h01 -> parity bit 1. Data=8'hFF -> parity bit 0. Data is changed to 8'h00 mid-frame -> transmitted bits unchanged.
4. Start held high, Data=8'h3C then 8'hC3 -> two frames. Second start bit begins at edge k+45. Tx=1 on cycle k+44. Start is ignored while Busy.
5. Reset pulsed during DATA bit 3 of 8'hA5 -> Tx=1 and Busy=0 immediately, no Done. The next Start sends a complete correct frame.
6. Instance WIDTH=4, CLKS_PER_BIT=1, PARITY_EN=0, Data=4'b0110 -> Tx per cycle 0,0,1,1,0,1. Done on cycle 6.

Source files
------------

// File: rtl/serial_tx.sv
// Serial transmitter for an idle-high line.
// Frame: start bit, WIDTH data bits LSB-first, optional even-parity bit, stop bit.
module serial_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter bit          PARITY_EN    = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    output logic             Tx,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bit_end;
    logic [WIDTH-1:0]   shifted;

    // Next-state: Tx is updated on the same edge that crosses each bit boundary.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CNT_LAST);
        shifted = shreg_q >> 1;

        if (state_q == S_IDLE) begin
            if (Start) begin
                shreg_d = Data;
                par_d   = ^Data;
                state_d = S_START;
                cnt_d   = '0;
                idx_d   = '0;
                tx_d    = 1'b0;
                busy_d  = 1'b1;
            end
        end else if (!bit_end) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
            unique case (state_q)
                S_START: begin
                    state_d = S_DATA;
                    idx_d   = '0;
                    tx_d    = shreg_q[0];
                end
                S_DATA: begin
                    shreg_d = shifted;
                    if (idx_q == IDX_LAST) begin
                        if (PARITY_EN) begin
                            state_d = S_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = S_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        tx_d  = shifted[0];
                    end
                end
                S_PARITY: begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Tx   = tx_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: scoreboarded default instance plus a small
// WIDTH=4 / one-cycle-per-bit / no-parity instance.
module tb_serial_tx;

    localparam int unsigned W   = 8;
    localparam int unsigned CPB = 4;
    localparam bit          PAR = 1'b1;
    localparam int unsigned F   = (W + 2 + 32'(PAR)) * CPB;

    localparam int unsigned W2   = 4;
    localparam int unsigned CPB2 = 1;
    localparam bit          PAR2 = 1'b0;
    localparam int unsigned F2   = (W2 + 2 + 32'(PAR2)) * CPB2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] data = '0;
    logic         tx, busy, done;

    logic          rst2 = 1'b1;
    logic          start2 = 1'b0;
    logic [W2-1:0] data2 = '0;
    logic          tx2, busy2, done2;
    bit            b_done = 1'b0;

    serial_tx #(.WIDTH(W), .CLKS_PER_BIT(CPB), .PARITY_EN(PAR)) dut (
        .Clock(clk), .Reset(rst), .Start(start), .Data(data),
        .Tx(tx), .Busy(busy), .Done(done)
    );

    serial_tx #(.WIDTH(W2), .CLKS_PER_BIT(CPB2), .PARITY_EN(PAR2)) dut2 (
        .Clock(clk), .Reset(rst2), .Start(start2), .Data(data2),
        .Tx(tx2), .Busy(busy2), .Done(done2)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Line level c cycles into a frame, straight from the frame layout.
    function automatic logic frame_bit(input int unsigned w, input int unsigned cpb,
                                       input bit par, input logic [31:0] d,
                                       input int unsigned c);
        int unsigned b;
        b = c / cpb;
        if (b == 0) return 1'b0;
        if (b <= w) return d[b-1];
        if (par && b == w + 1) return ^d;
        return 1'b1;
    endfunction

    typedef struct {
        logic [W-1:0] d;
        int unsigned  acc;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc     = 0;
    int unsigned free_at = 0;

    // Reference model: a Start is taken when at least F+1 edges have passed since the last accept.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            exp_q.delete();
            free_at = cyc + 1;
        end else if (start && cyc >= free_at) begin
            exp_q.push_back('{d: data, acc: cyc});
            free_at = cyc + F + 1;
        end
    end

    int unsigned n_cap = 0;

    // Monitor: checks every line sample against the frame at the head of the queue.
    always @(negedge clk) begin
        if (rst) begin
            n_cap = 0;
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end else if (busy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_frame: got busy with no accepted start at t=%0t", $time);
            end else begin
                if (n_cap == 0) check("accept_edge", cyc, exp_q[0].acc);
                check("tx_bit", 32'(tx), 32'(frame_bit(W, CPB, PAR, 32'(exp_q[0].d), n_cap)));
            end
            check("done_while_busy", 32'(done), 32'd0);
            n_cap++;
        end else begin
            check("tx_idle", 32'(tx), 32'd1);
            if (done) begin
                check("frame_len", n_cap, F);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                n_cap = 0;
            end else if (n_cap != 0) begin
                check("done_missing", 32'(done), 32'd1);
                n_cap = 0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] d);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        data  = W'($urandom);
    endtask

    initial begin
        tick(3);
        rst = 1'b0;
        tick(20);

        send(8'hA5);
        data = 8'h00;
        tick(F + 4);
        send(8'h01);
        tick(F + 4);
        send(8'hFF);
        data = 8'h00;
        tick(F + 4);

        // Start held across two frames
        data  = 8'h3C;
        start = 1'b1;
        @(negedge clk);
        data = 8'hC3;
        tick(F + 1);
        start = 1'b0;
        tick(F + 4);

        // Reset during data bit 3
        send(8'hA5);
        tick(16);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx", 32'(tx), 32'd1);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_done", 32'(done), 32'd0);
        @(posedge clk);
        #2 rst = 1'b0;
        data  = 8'h5A;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tick(F + 4);

        repeat (800) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            data  = W'($urandom);
        end
        start = 1'b0;
        tick(F + 4);

        check("queue_drained", exp_q.size(), 32'd0);
        check("no_partial_frame", n_cap, 32'd0);
        wait (b_done);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Narrow instance: one cycle per bit, no parity.
    initial begin
        tick(3);
        rst2 = 1'b0;
        tick(2);
        check("b_idle_tx", 32'(tx2), 32'd1);
        check("b_idle_busy", 32'(busy2), 32'd0);
        data2  = 4'b0110;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        data2  = 4'b1001;
        for (int c = 0; c < int'(F2); c++) begin
            check("b_tx", 32'(tx2), 32'(frame_bit(W2, CPB2, PAR2, 32'(4'b0110), c)));
            check("b_busy", 32'(busy2), 32'd1);
            check("b_done_low", 32'(done2), 32'd0);
            @(negedge clk);
        end
        check("b_done", 32'(done2), 32'd1);
        check("b_end_busy", 32'(busy2), 32'd0);
        check("b_end_tx", 32'(tx2), 32'd1);
        @(negedge clk);
        check("b_done_clear", 32'(done2), 32'd0);
        b_done = 1'b1;
    end

endmodule
